onchip_mem_dp_ctrl: RTL
=======================

Name: onchip_mem_dp_ctrl

Overview:
Parametrised dual-port on-chip RAM with two independent Avalon-MM slaves: s1 for the CPU and s2 for the capture/display path.
Generalises the 8-bit single-port memory with:
- configurable data width and depth
- byte enables
- selectable read latency with readdatavalid
- a post-reset zero-fill engine that holds off both ports with waitrequest
- defined cross-port collision rules

It sits in the SOPC system as the shared sample/display buffer between the Nios and the capture logic.

Parameters:
DATA_W, 8, data width in bits; must be a multiple of 8.
DEPTH, 40096, number of words; must be between 1 and 2^ADDR_W.
ADDR_W, 16, word address width.
READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values 1 or 2.
CLEAR_ON_RESET, 1, 1 = zero-fill the whole array after reset; 0 = skip the fill.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- clken  in  1  global clock enable; low freezes all state.
- reset_req  in  1  reset-request hold-off; same effect as clken=0.
- s1_address / s2_address  in  ADDR_W  word address.
- s1_chipselect / s2_chipselect  in  1  slave select.
- s1_read / s2_read  in  1  read strobe.
- s1_write / s2_write  in  1  write strobe.
- s1_writedata / s2_writedata  in  DATA_W  write data.
- s1_byteenable / s2_byteenable  in  DATA_W/8  per-byte write enable.
- s1_readdata / s2_readdata  out  DATA_W  read data.
- s1_readdatavalid / s2_readdatavalid  out  1  one-cycle read-data-valid pulse.
- s1_waitrequest / s2_waitrequest  out  1  stall.
- busy_clearing  out  1  zero-fill in progress.

Behaviour:
Clock and reset:
- One clock (clk); reset is synchronous and active-high.

Reset values:
- readdata = 0, readdatavalid = 0, waitrequest = 1, read pipeline flushed.
- busy_clearing = CLEAR_ON_RESET.
- clr_addr = 0.
- State = CLEAR if CLEAR_ON_RESET, else RUN.

State machine:
- CLEAR:
  - Each enabled cycle writes 0 to clr_addr on port A, then increments clr_addr.
  - On the write to DEPTH-1: next state RUN, busy_clearing drops.
  - Both waitrequests stay high throughout CLEAR.
- RUN:
  - waitrequest = ~en, where en = clken & ~reset_req.
- Reset asserted mid-CLEAR or mid-RUN: restarts CLEAR at address 0 and discards in-flight reads (no readdatavalid is issued for them).

Access acceptance:
- accept = chipselect & (read | write) & ~waitrequest.
- If read and write are both high, the write wins; no readdatavalid is produced.
- Writes update only the bytes whose byteenable bit is 1; byteenable = 0 is a legal no-op write.
- Reads return the full word; byteenable is ignored on reads.

Read latency:
- An accepted read at cycle N gives readdatavalid = 1 at cycle N+READ_LATENCY, with readdata valid in that same cycle.
- Throughput: one read per port per cycle; back-to-back reads give back-to-back valids.
- readdata holds its last value when readdatavalid = 0.

Out-of-range addresses (address >= DEPTH):
- Writes are dropped.
- Reads return 0, with readdatavalid at the normal latency.

Clock enable:
- clken = 0 or reset_req = 1 freezes the read pipeline, the clear counter, the FSM and readdatavalid (no new pulses, no pulse is lost).
- Pending valids emerge once enable returns.

Cross-port collisions, same address, same cycle:
- Both ports write: byte lanes enabled on s1 take s1 data; lanes enabled only on s2 take s2 data. No stall on either port.
- One port writes, the other reads: the read returns the pre-write (old) data, unless the RDW feature below is enabled.
- Same-port read-after-write in consecutive cycles returns the new data.

Optional Feature:
Macro: ONCHIP_MEM_DP_RDW_FWD_EN.
- Defined: on a cross-port same-cycle write/read to the same address, the read returns the new data. Enabled bytes come from the writer; the other bytes come from memory. This adds a forwarding mux at the read output stage. Latency is unchanged.
- Undefined: the read returns the old data, and no forwarding logic is generated.

Decomposition:
- Package onchip_mem_dp_pkg:
  - FSM state typedef (ST_CLEAR, ST_RUN).
  - Legal READ_LATENCY constants.
  - Function for the byte-merge of writedata and byteenable.
- Sub-module onchip_mem_dp_ram:
  - Inferred true-dual-port byte-enabled RAM with one registered read stage.
  - The top level adds the optional second stage, the valid pipeline, the clear FSM, the collision logic and the forwarding.

Test Plan:
1. Reset with CLEAR_ON_RESET=1, DEPTH=16: busy_clearing and both waitrequests high for exactly 16 enabled cycles, then low; a read of every address returns 0.
2. READ_LATENCY=2, s1 writes 0xA5 to addr 3, then reads addr 3 twice back-to-back: readdatavalid high at N+2 and N+3, readdata = 0xA5 both times.
3. DATA_W=32, both ports write addr 5 in the same cycle (s1 data 0x11223344 be 0011; s2 data 0xAABBCCDD be 1110): memory = 0xAABB3344.
4. Same cycle, s1 writes 0x5A to addr 7 (old 0x00) and s2 reads addr 7: s2 gets 0x00 with the macro undefined, 0x5A with ONCHIP_MEM_DP_RDW_FWD_EN defined.
5. Read issued, clken low for 3 cycles, then clken restored: readdatavalid arrives exactly READ_LATENCY enabled cycles after accept; no pulse is lost or duplicated.
6. Reset at clear address 9 of 16: CLEAR restarts at 0 and takes 16 more enabled cycles; a read of address 20 (>= DEPTH) returns 0 with valid at normal latency.

Source files
------------

// File: rtl/onchip_mem_dp_pkg.sv
// Shared types and helpers for the dual-port on-chip memory controller.
// Holds the clear/run FSM encoding, the legal read latencies and the byte-merge helper.
package onchip_mem_dp_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/onchip_mem_dp_ram.sv
// True-dual-port byte-lane RAM with one registered read stage (read-before-write).
// Port A lanes override port B lanes when both write the same word in the same cycle.
module onchip_mem_dp_ram
  import onchip_mem_dp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4
) (
  input  logic                clk,
  input  logic                rd_en,
  input  logic [IDX_W-1:0]    addr_a,
  input  logic [DATA_W/8-1:0] we_a,
  input  logic [DATA_W-1:0]   wd_a,
  output logic [DATA_W-1:0]   q_a,
  input  logic [IDX_W-1:0]    addr_b,
  input  logic [DATA_W/8-1:0] we_b,
  input  logic [DATA_W-1:0]   wd_b,
  output logic [DATA_W-1:0]   q_b
);

  localparam int NB = DATA_W / 8;

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] qa_reg;
    logic [7:0] qb_reg;

    always_ff @(posedge clk) begin
      if (we_b[gi]) mem[addr_b] <= wd_b[gi*8 +: 8];
      if (we_a[gi]) mem[addr_a] <= wd_a[gi*8 +: 8];
      if (rd_en) begin
        qa_reg <= mem[addr_a];
        qb_reg <= mem[addr_b];
      end
    end

    assign q_a[gi*8 +: 8] = qa_reg;
    assign q_b[gi*8 +: 8] = qb_reg;
  end

endmodule

// File: rtl/onchip_mem_dp_ctrl.sv
// Dual-port Avalon-MM on-chip RAM: post-reset zero fill, 1/2-cycle read latency, byte enables.
// Define ONCHIP_MEM_DP_RDW_FWD_EN to forward same-cycle cross-port writes into reads.
module onchip_mem_dp_ctrl
  import onchip_mem_dp_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int DEPTH          = 40096,
  parameter int ADDR_W         = 16,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clken,
  input  logic                reset_req,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W-1:0]   s1_writedata,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W-1:0]   s2_writedata,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest,
  output logic                busy_clearing
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT   = (READ_LATENCY > RD_LAT_MIN) ? RD_LAT_MAX : RD_LAT_MIN;
  localparam logic [ADDR_W:0]  DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam state_e ST_INIT = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  logic             en, busy, stall;
  state_e           state_reg, state_next;
  logic [IDX_W-1:0] clr_addr_reg, clr_addr_next;

  assign en             = clken & ~reset_req;
  assign busy           = (state_reg == ST_CLEAR);
  assign busy_clearing  = busy;
  assign stall          = reset | busy | ~en;
  assign s1_waitrequest = stall;
  assign s2_waitrequest = stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_INIT;
      clr_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    if (en && state_reg == ST_CLEAR) begin
      if (clr_addr_reg == LAST_IDX) state_next = ST_RUN;
      else clr_addr_next = clr_addr_reg + 1'b1;
    end
  end

  // Index 0 is s1 (RAM port A, shared with the clear engine), index 1 is s2.
  logic [ADDR_W-1:0] p_addr  [2];
  logic              p_cs    [2];
  logic              p_rd    [2];
  logic              p_wr    [2];
  logic [DATA_W-1:0] p_wd    [2];
  logic [NB-1:0]     p_be    [2];
  logic [IDX_W-1:0]  p_idx   [2];
  logic              p_wr_ok [2];
  logic              p_rd_acc[2];
  logic [DATA_W-1:0] p_q     [2];
  logic [DATA_W-1:0] p_rdata [2];
  logic              p_rvalid[2];

  assign p_addr[0] = s1_address;    assign p_addr[1] = s2_address;
  assign p_cs[0]   = s1_chipselect; assign p_cs[1]   = s2_chipselect;
  assign p_rd[0]   = s1_read;       assign p_rd[1]   = s2_read;
  assign p_wr[0]   = s1_write;      assign p_wr[1]   = s2_write;
  assign p_wd[0]   = s1_writedata;  assign p_wd[1]   = s2_writedata;
  assign p_be[0]   = s1_byteenable; assign p_be[1]   = s2_byteenable;
  assign s1_readdata      = p_rdata[0];
  assign s2_readdata      = p_rdata[1];
  assign s1_readdatavalid = p_rvalid[0];
  assign s2_readdatavalid = p_rvalid[1];

  logic [IDX_W-1:0]  ram_addr_a;
  logic [NB-1:0]     ram_we_a, ram_we_b;
  logic [DATA_W-1:0] ram_wd_a;

  assign ram_addr_a = busy ? clr_addr_reg : p_idx[0];
  assign ram_we_a   = busy ? {NB{en}} : (p_wr_ok[0] ? p_be[0] : '0);
  assign ram_wd_a   = busy ? '0 : p_wd[0];
  assign ram_we_b   = p_wr_ok[1] ? p_be[1] : '0;

  onchip_mem_dp_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rd_en (en),
    .addr_a(ram_addr_a),
    .we_a  (ram_we_a),
    .wd_a  (ram_wd_a),
    .q_a   (p_q[0]),
    .addr_b(p_idx[1]),
    .we_b  (ram_we_b),
    .wd_b  (p_wd[1]),
    .q_b   (p_q[1])
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic              acc, in_range;
    logic              v1_reg, oor1_reg;
    logic [DATA_W-1:0] d1;

    assign in_range      = ({1'b0, p_addr[gi]} < DEPTH_W);
    assign p_idx[gi]     = p_addr[gi][IDX_W-1:0];
    assign acc           = p_cs[gi] & (p_rd[gi] | p_wr[gi]) & ~stall;
    assign p_wr_ok[gi]   = acc & p_wr[gi] & in_range;
    assign p_rd_acc[gi]  = acc & p_rd[gi] & ~p_wr[gi];

    always_ff @(posedge clk) begin
      if (reset) begin
        v1_reg   <= 1'b0;
        oor1_reg <= 1'b0;
      end else if (en) begin
        v1_reg   <= p_rd_acc[gi];
        oor1_reg <= ~in_range;
      end
    end

`ifdef ONCHIP_MEM_DP_RDW_FWD_EN
    // Capture the opposite port's same-address write so its bytes replace the stale RAM read.
    logic [NB-1:0]     fwd_be, fwd_be1_reg;
    logic [DATA_W-1:0] fwd_d1_reg;

    assign fwd_be = (p_rd_acc[gi] && p_wr_ok[1-gi] && p_addr[1-gi] == p_addr[gi]) ?
                    p_be[1-gi] : '0;

    always_ff @(posedge clk) begin
      if (reset) begin
        fwd_be1_reg <= '0;
        fwd_d1_reg  <= '0;
      end else if (en) begin
        fwd_be1_reg <= fwd_be;
        fwd_d1_reg  <= p_wd[1-gi];
      end
    end

    always_comb begin
      d1 = p_q[gi];
      for (int b = 0; b < NB; b++)
        d1[b*8 +: 8] = merge_byte(p_q[gi][b*8 +: 8], fwd_d1_reg[b*8 +: 8], fwd_be1_reg[b]);
      if (oor1_reg) d1 = '0;
    end
`else
    assign d1 = oor1_reg ? '0 : p_q[gi];
`endif

    if (LAT == RD_LAT_MAX) begin : g_lat2
      logic              v2_reg;
      logic [DATA_W-1:0] q2_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          v2_reg <= 1'b0;
          q2_reg <= '0;
        end else if (en) begin
          v2_reg <= v1_reg;
          if (v1_reg) q2_reg <= d1;
        end
      end

      assign p_rvalid[gi] = v2_reg & en;
      assign p_rdata[gi]  = q2_reg;
    end else begin : g_lat1
      logic [DATA_W-1:0] hold_reg;

      always_ff @(posedge clk) begin
        if (reset) hold_reg <= '0;
        else if (p_rvalid[gi]) hold_reg <= d1;
      end

      assign p_rvalid[gi] = v1_reg & en;
      assign p_rdata[gi]  = p_rvalid[gi] ? d1 : hold_reg;
    end
  end

endmodule
